// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the load/store unit (slave).
interface data_mem_lsu_if #(
  parameter int MP_WIDTH      = 32,
  parameter int MP_ADDR_WIDTH = 32
);
  logic                     ireq_valid;
  logic                     oreq_ready;
  logic [MP_ADDR_WIDTH-1:0] iaddr;
  logic                     iwen;
  logic [1:0]               isize;
  logic                     iunsigned;
  logic [MP_WIDTH-1:0]      iwdata;
  logic                     orsp_valid;
  logic [MP_WIDTH-1:0]      ordata;
  logic                     oerr;

  modport master (
    output ireq_valid, iaddr, iwen, isize, iunsigned, iwdata,
    input  oreq_ready, orsp_valid, ordata, oerr
  );

  modport slave (
    input  ireq_valid, iaddr, iwen, isize, iunsigned, iwdata,
    output oreq_ready, orsp_valid, ordata, oerr
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Data memory with a load/store front end: byte-lane stores, sign/zero-extended loads,
// and word-boundary-crossing accesses split into two consecutive word accesses.
module data_mem_lsu #(
  parameter int MP_WIDTH      = 32,
  parameter int MP_ADDR_WIDTH = 32,
  parameter int MP_DEPTH      = 256,
  parameter bit MP_MISALIGN   = 1'b1
) (
  input logic            iclk,
  input logic            irst,
  data_mem_lsu_if.slave  bus
);
  localparam int NB   = MP_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = (MP_DEPTH > 1) ? $clog2(MP_DEPTH) : 1;
  localparam int SBW  = $clog2(MP_WIDTH);
  localparam logic [MP_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  // Word index of a byte address, wrapped into the RAM depth.
  function automatic logic [IDXW-1:0] to_idx(input logic [MP_ADDR_WIDTH-1:0] a);
    logic [MP_ADDR_WIDTH-1:0] w;
    w = a >> OFFW;
    return IDXW'(w % MP_ADDR_WIDTH'(MP_DEPTH));
  endfunction

  state_t              state_q, state_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [IDXW-1:0]     idx1_q, idx1_d;
  logic                wen_q, wen_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [MP_WIDTH-1:0] wdata_q, wdata_d;
  logic                cross_q, cross_d;
  logic [MP_WIDTH-1:0] lo_q, lo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [MP_WIDTH-1:0] ordata_q, ordata_d;
  logic                err_q, err_d;

  logic [MP_WIDTH-1:0] ram_q [MP_DEPTH];
  logic [MP_WIDTH-1:0] ram_rdata_q;
  logic [IDXW-1:0]     ram_raddr;
  logic [IDXW-1:0]     ram_waddr;
  logic [NB-1:0]       ram_we;
  logic [MP_WIDTH-1:0] ram_wdata;

  logic                accept;
  logic [OFFW-1:0]     req_off;
  logic [IDXW-1:0]     req_idx;
  logic [IDXW-1:0]     req_idx1;
  logic                req_cross;
  logic                req_err;

  logic [2*NB-1:0]       be_pair;
  logic [2*MP_WIDTH-1:0] wd_pair;
  logic [MP_WIDTH-1:0]   lo_word;
  logic [MP_WIDTH-1:0]   hi_word;
  logic [MP_WIDTH-1:0]   raw;
  logic [MP_WIDTH-1:0]   mask;
  logic [MP_WIDTH-1:0]   load_ext;
  logic [SBW-1:0]        sbit;

  assign accept = bus.ireq_valid && (state_q == S_IDLE) && !irst;

  assign bus.oreq_ready = (state_q == S_IDLE) && !irst;
  assign bus.orsp_valid = rsp_valid_q;
  assign bus.ordata     = ordata_q;
  assign bus.oerr       = err_q;

  // Decode the incoming request: word index, offset, crossing and error classification.
  always_comb begin
    int nbytes;
    nbytes    = 1 << bus.isize;
    req_off   = bus.iaddr[OFFW-1:0];
    req_idx   = to_idx(bus.iaddr);
    req_idx1  = (req_idx == IDXW'(MP_DEPTH - 1)) ? '0 : req_idx + 1'b1;
    req_cross = (int'(req_off) + nbytes) > NB;
    req_err   = ((bus.isize == 2'b11) && (MP_WIDTH == 32)) || (req_cross && !MP_MISALIGN);
  end

  // Byte-lane enables and store data over the {word idx+1, word idx} pair, plus load assembly.
  always_comb begin
    int nbytes;
    int nbits;
    nbytes  = 1 << size_q;
    nbits   = 8 << size_q;
    for (int k = 0; k < 2 * NB; k++) begin
      be_pair[k] = (k >= int'(off_q)) && (k < int'(off_q) + nbytes);
    end
    wd_pair  = {{MP_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
    lo_word  = (state_q == S_ACC1) ? lo_q : ram_rdata_q;
    hi_word  = (state_q == S_ACC1) ? ram_rdata_q : '0;
    raw      = MP_WIDTH'({hi_word, lo_word} >> {off_q, 3'b000});
    mask     = (nbits >= MP_WIDTH) ? ONES : ~(ONES << nbits);
    sbit     = SBW'(nbits - 1);
    load_ext = raw & mask;
    if (!uns_q && (nbits < MP_WIDTH) && raw[sbit]) begin
      load_ext = load_ext | ~mask;
    end
  end

  // Next-state logic: request latch, FSM sequencing, RAM port control and response formation.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    idx_d       = idx_q;
    idx1_d      = idx1_q;
    wen_d       = wen_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    cross_d     = cross_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    ordata_d    = ordata_q;
    err_d       = err_q;
    ram_we      = '0;
    ram_waddr   = idx_q;
    ram_wdata   = wd_pair[MP_WIDTH-1:0];
    // The read for word idx is issued on the accept edge so its data is ready in ACC0.
    ram_raddr   = (state_q == S_IDLE) ? req_idx : idx1_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          off_d   = req_off;
          idx_d   = req_idx;
          idx1_d  = req_idx1;
          wen_d   = bus.iwen;
          size_d  = bus.isize;
          uns_d   = bus.iunsigned;
          wdata_d = bus.iwdata;
          cross_d = req_cross;
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            ordata_d    = '0;
            err_d       = 1'b1;
          end else begin
            state_d = S_ACC0;
          end
        end
      end
      S_ACC0: begin
        ram_waddr = idx_q;
        ram_wdata = wd_pair[MP_WIDTH-1:0];
        if (wen_q && !irst) ram_we = be_pair[NB-1:0];
        lo_d = ram_rdata_q;
        if (cross_q) begin
          state_d = S_ACC1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          ordata_d    = wen_q ? '0 : load_ext;
          err_d       = 1'b0;
        end
      end
      S_ACC1: begin
        ram_waddr = idx1_q;
        ram_wdata = wd_pair[2*MP_WIDTH-1:MP_WIDTH];
        if (wen_q && !irst) ram_we = be_pair[2*NB-1:NB];
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        ordata_d    = wen_q ? '0 : load_ext;
        err_d       = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers; reset abandons any request in flight.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      idx_q       <= '0;
      idx1_q      <= '0;
      wen_q       <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      cross_q     <= 1'b0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      ordata_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      idx_q       <= idx_d;
      idx1_q      <= idx1_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      cross_q     <= cross_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      ordata_q    <= ordata_d;
      err_q       <= err_d;
    end
  end

  // Word RAM: per-byte write enables, registered read, contents never reset.
  always_ff @(posedge iclk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_we[b]) ram_q[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata_q <= ram_q[ram_raddr];
  end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench: three LSU instances (default, 4-word depth, misaligned disabled),
// a vector table of transactions plus a hand-written reset-in-flight sequence.
module tb_data_mem_lsu;
  logic clk;
  logic rst;

  logic        d_valid [3];
  logic [31:0] d_addr  [3];
  logic        d_wen   [3];
  logic [1:0]  d_size  [3];
  logic        d_uns   [3];
  logic [31:0] d_wdata [3];
  wire         o_ready [3];
  wire         o_rsp   [3];
  wire  [31:0] o_rdata [3];
  wire         o_err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_mem_lsu_if #(.MP_WIDTH(32), .MP_ADDR_WIDTH(32)) bus ();
    assign bus.ireq_valid = d_valid[gi];
    assign bus.iaddr      = d_addr[gi];
    assign bus.iwen       = d_wen[gi];
    assign bus.isize      = d_size[gi];
    assign bus.iunsigned  = d_uns[gi];
    assign bus.iwdata     = d_wdata[gi];
    assign o_ready[gi]    = bus.oreq_ready;
    assign o_rsp[gi]      = bus.orsp_valid;
    assign o_rdata[gi]    = bus.ordata;
    assign o_err[gi]      = bus.oerr;
    data_mem_lsu #(
      .MP_WIDTH(32),
      .MP_ADDR_WIDTH(32),
      .MP_DEPTH((gi == 1) ? 4 : 256),
      .MP_MISALIGN((gi == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .iclk(clk),
      .irst(rst),
      .bus(bus)
    );
  end

  typedef struct {
    int          sel;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int s, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                     input logic ee, input int el);
    vec_t v;
    v.sel = s; v.wen = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rd = er; v.exp_err = ee; v.exp_lat = el;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on instance s and wait (bounded) for its response.
  task automatic do_req(input int s, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    while (o_ready[s] !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    d_valid[s] = 1'b1; d_wen[s] = w; d_size[s] = sz; d_uns[s] = u;
    d_addr[s] = a; d_wdata[s] = wd;
    @(posedge clk);
    @(negedge clk);
    d_valid[s] = 1'b0;
    lat = 1;
    while (o_rsp[s] !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rd = o_rdata[s];
    er = o_err[s];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    for (int i = 0; i < 3; i++) begin
      d_valid[i] = 1'b0; d_addr[i] = '0; d_wen[i] = 1'b0;
      d_size[i] = '0; d_uns[i] = 1'b0; d_wdata[i] = '0;
    end

    // Instance 0: 32-bit, 256 words, misaligned split enabled
    add(0, 1, 2, 0, 32'h10,  32'h8000_00F0, 32'h0,          0, 2);
    add(0, 0, 2, 0, 32'h10,  32'h0,         32'h8000_00F0, 0, 2);
    add(0, 1, 0, 0, 32'h13,  32'h1234_56AB, 32'h0,          0, 2);
    add(0, 0, 0, 0, 32'h13,  32'h0,         32'hFFFF_FFAB, 0, 2);
    add(0, 0, 0, 1, 32'h13,  32'h0,         32'h0000_00AB, 0, 2);
    add(0, 0, 2, 0, 32'h10,  32'h0,         32'hAB00_00F0, 0, 2);
    add(0, 1, 2, 0, 32'h14,  32'h1122_3344, 32'h0,          0, 2);
    add(0, 1, 1, 0, 32'h13,  32'hDEAD_BEEF, 32'h0,          0, 3);
    add(0, 0, 1, 1, 32'h13,  32'h0,         32'h0000_BEEF, 0, 3);
    add(0, 0, 1, 0, 32'h13,  32'h0,         32'hFFFF_BEEF, 0, 3);
    add(0, 0, 2, 0, 32'h10,  32'h0,         32'hEF00_00F0, 0, 2);
    add(0, 0, 2, 0, 32'h14,  32'h0,         32'h1122_33BE, 0, 2);
    add(0, 0, 2, 0, 32'h12,  32'h0,         32'h33BE_EF00, 0, 3);
    add(0, 0, 1, 0, 32'h12,  32'h0,         32'hFFFF_EF00, 0, 2);
    add(0, 0, 0, 0, 32'h14,  32'h0,         32'hFFFF_FFBE, 0, 2);
    add(0, 0, 3, 0, 32'h20,  32'h0,         32'h0,          1, 1);
    add(0, 0, 2, 0, 32'h410, 32'h0,         32'hEF00_00F0, 0, 2);
    add(0, 1, 2, 0, 32'h20,  32'hA0A0_A0A0, 32'h0,          0, 2);
    add(0, 1, 2, 0, 32'h24,  32'hB0B0_B0B0, 32'h0,          0, 2);
    // Instance 1: 4-word RAM, crossing store wraps from word 3 to word 0
    add(1, 1, 2, 0, 32'h0C,  32'hAAAA_AAAA, 32'h0,          0, 2);
    add(1, 1, 2, 0, 32'h00,  32'h5555_5555, 32'h0,          0, 2);
    add(1, 1, 2, 0, 32'h0E,  32'h1122_3344, 32'h0,          0, 3);
    add(1, 0, 2, 0, 32'h0C,  32'h0,         32'h3344_AAAA, 0, 2);
    add(1, 0, 2, 0, 32'h00,  32'h0,         32'h5555_1122, 0, 2);
    add(1, 0, 2, 0, 32'h10,  32'h0,         32'h5555_1122, 0, 2);
    // Instance 2: misaligned crossing reported as error
    add(2, 1, 2, 0, 32'h00,  32'hCAFE_F00D, 32'h0,          0, 2);
    add(2, 0, 2, 0, 32'h02,  32'h0,         32'h0,          1, 1);
    add(2, 1, 2, 0, 32'h02,  32'hFFFF_FFFF, 32'h0,          1, 1);
    add(2, 1, 3, 0, 32'h00,  32'h1234_5678, 32'h0,          1, 1);
    add(2, 0, 2, 0, 32'h00,  32'h0,         32'hCAFE_F00D, 0, 2);
    add(2, 0, 1, 0, 32'h02,  32'h0,         32'hFFFF_CAFE, 0, 2);
    add(2, 0, 1, 1, 32'h03,  32'h0,         32'h0,          1, 1);
    add(2, 0, 0, 1, 32'h03,  32'h0,         32'h0000_00CA, 0, 2);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_ready%0d", i), {31'b0, o_ready[i]}, 32'h0);
    chk("reset_rsp_valid", {31'b0, o_rsp[0]}, 32'h0);
    chk("reset_ordata",    o_rdata[0],        32'h0);
    chk("reset_oerr",      {31'b0, o_err[0]}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("post_reset_ready%0d", i), {31'b0, o_ready[i]}, 32'h1);

    for (int i = 0; i < vt.size(); i++) begin
      do_req(vt[i].sel, vt[i].wen, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat);
      $display("txn %0d dut%0d wen=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               i, vt[i].sel, vt[i].wen, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_ordata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_oerr", i), {31'b0, er}, {31'b0, vt[i].exp_err});
      @(negedge clk);
      chk($sformatf("v%0d_rsp_one_cycle", i), {31'b0, o_rsp[vt[i].sel]}, 32'h0);
      chk($sformatf("v%0d_ordata_held", i), o_rdata[vt[i].sel], vt[i].exp_rd);
    end

    // Reset during ACC1 of a crossing store: only the first word is written
    d_valid[0] = 1'b1; d_wen[0] = 1'b1; d_size[0] = 2'd2; d_uns[0] = 1'b0;
    d_addr[0] = 32'h22; d_wdata[0] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("t6_ready_low_acc0", {31'b0, o_ready[0]}, 32'h0);
    d_addr[0] = 32'h24; d_wdata[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t6_no_rsp_acc1", {31'b0, o_rsp[0]}, 32'h0);
    rst = 1'b1;
    d_valid[0] = 1'b0;
    @(negedge clk);
    chk("t6_ready_low_rst", {31'b0, o_ready[0]}, 32'h0);
    chk("t6_no_rsp_rst",    {31'b0, o_rsp[0]},   32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t6_ready_after_%0d", c), {31'b0, o_ready[0]}, 32'h1);
      chk($sformatf("t6_no_rsp_after_%0d", c), {31'b0, o_rsp[0]}, 32'h0);
    end
    $display("txn t6 dut0 crossing SW 0x12345678 @0x22 aborted by reset in ACC1");
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    $display("txn t6a dut0 LW @00000020 -> rdata=%h err=%0d lat=%0d", rd, er, lat);
    chk("t6_word0_written", rd, 32'h5678_A0A0);
    chk("t6_word0_lat", 32'(lat), 32'd2);
    @(negedge clk);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lat);
    $display("txn t6b dut0 LW @00000024 -> rdata=%h err=%0d lat=%0d", rd, er, lat);
    chk("t6_word1_untouched", rd, 32'hB0B0_B0B0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
